vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for a VGA-style display.
// A clock divider produces one pixel advance every CLK_DIV clk cycles; on
// each advance the horizontal/vertical counters step through the full
// raster, and all decoded outputs (video_on, syncs) are registered from the
// next counter values so they change only on advance edges. pix_tick,
// frame_start and vblank_start are single-clk strobes in the cycle after
// the advance that produced them.
module vga_timing_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int CLK_DIV         = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pix_tick,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       vblank_start
);

  // Raster geometry. Totals may reach 1024, so window bounds are kept in
  // 11 bits and counters are zero-extended before comparison.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [7:0]  DIV_MAX  = 8'(CLK_DIV - 1);
  localparam logic [9:0]  X_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_VBLANK = 10'(V_ACTIVE);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Level driven on the sync pins when the sync window is not active.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  // True when pos lies strictly below lim.
  function automatic logic below(input logic [9:0] pos, input logic [10:0] lim);
    return ({1'b0, pos} < lim);
  endfunction

  // True when pos lies in the half-open window [lo, hi).
  function automatic logic in_window(input logic [9:0] pos, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
  endfunction

  // Map a logical "sync asserted" flag onto the pin polarity.
  function automatic logic sync_level(input logic asserted);
    return asserted ^ SYNC_IDLE;
  endfunction

  logic [7:0] div_cnt_r;
  logic [9:0] x_r;
  logic [9:0] y_r;
  logic       video_on_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       pix_tick_r;
  logic       frame_start_r;
  logic       vblank_start_r;

  logic       div_last_s;
  logic       advance_s;
  logic [7:0] div_next_s;
  logic       x_wrap_s;
  logic [9:0] x_next_s;
  logic [9:0] y_next_s;
  logic       video_next_s;
  logic       hsync_next_s;
  logic       vsync_next_s;
  logic       frame_hit_s;
  logic       vblank_hit_s;

  // Divider: counts only while enabled, so a hold resumes exactly where it stopped.
  always_comb begin
    div_last_s = (div_cnt_r == DIV_MAX);
    advance_s  = enable & div_last_s;
    div_next_s = div_cnt_r;
    if (!enable) begin
      div_next_s = div_cnt_r;
    end else if (div_last_s) begin
      div_next_s = 8'd0;
    end else begin
      div_next_s = div_cnt_r + 8'd1;
    end
  end

  // Next raster position: x steps on every advance, y only when x wraps.
  always_comb begin
    x_wrap_s = (x_r == X_MAX);
    x_next_s = x_r;
    y_next_s = y_r;
    if (!advance_s) begin
      x_next_s = x_r;
    end else if (x_wrap_s) begin
      x_next_s = 10'd0;
    end else begin
      x_next_s = x_r + 10'd1;
    end
    if (!(advance_s && x_wrap_s)) begin
      y_next_s = y_r;
    end else if (y_r == Y_MAX) begin
      y_next_s = 10'd0;
    end else begin
      y_next_s = y_r + 10'd1;
    end
  end

  // Decode of the next position, registered below so outputs line up with the counters.
  always_comb begin
    video_next_s = below(x_next_s, H_ACT) && below(y_next_s, V_ACT);
    hsync_next_s = sync_level(in_window(x_next_s, HS_BEG, HS_END));
    vsync_next_s = sync_level(in_window(y_next_s, VS_BEG, VS_END));
    frame_hit_s  = (x_next_s == 10'd0) && (y_next_s == 10'd0);
    vblank_hit_s = (x_next_s == 10'd0) && (y_next_s == Y_VBLANK);
  end

  // Divider and raster counters; reset parks the raster on its last pixel
  // so the first advance lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= 8'd0;
      x_r       <= X_MAX;
      y_r       <= Y_MAX;
    end else begin
      div_cnt_r <= div_next_s;
      x_r       <= x_next_s;
      y_r       <= y_next_s;
    end
  end

  // Level outputs: change only on advance edges, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_on_r <= 1'b0;
      hsync_r    <= SYNC_IDLE;
      vsync_r    <= SYNC_IDLE;
    end else if (advance_s) begin
      video_on_r <= video_next_s;
      hsync_r    <= hsync_next_s;
      vsync_r    <= vsync_next_s;
    end else begin
      video_on_r <= video_on_r;
      hsync_r    <= hsync_r;
      vsync_r    <= vsync_r;
    end
  end

  // Strobes: set by an advance edge, cleared by the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_tick_r     <= 1'b0;
      frame_start_r  <= 1'b0;
      vblank_start_r <= 1'b0;
    end else begin
      pix_tick_r     <= advance_s;
      frame_start_r  <= advance_s & frame_hit_s;
      vblank_start_r <= advance_s & vblank_hit_s;
    end
  end

  assign pix_tick     = pix_tick_r;
  assign x_pos        = x_r;
  assign y_pos        = y_r;
  assign video_on     = video_on_r;
  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign frame_start  = frame_start_r;
  assign vblank_start = vblank_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives three timing generators (default 640x480 with
// CLK_DIV=2, and a tiny 15x11 raster at CLK_DIV=1 active-high and CLK_DIV=3
// active-low) from one clock/reset/enable, and compares every output each
// cycle with a model that derives the raster position from the number of
// enabled clk edges since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
  } vec_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b1;

  logic       a_pt, a_von, a_hs, a_vs, a_fs, a_vb;
  logic [9:0] a_x, a_y;
  logic       b_pt, b_von, b_hs, b_vs, b_fs, b_vb;
  logic [9:0] b_x, b_y;
  logic       c_pt, c_von, c_hs, c_vs, c_fs, c_vb;
  logic [9:0] c_x, c_y;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e_cnt  = 0;
  bit last_en = 1'b0;

  vec_t obs_a, obs_b, obs_c;
  assign obs_a = {a_pt, a_x, a_y, a_von, a_hs, a_vs, a_fs, a_vb};
  assign obs_b = {b_pt, b_x, b_y, b_von, b_hs, b_vs, b_fs, b_vb};
  assign obs_c = {c_pt, c_x, c_y, c_von, c_hs, c_vs, c_fs, c_vb};

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(a_pt), .x_pos(a_x),
    .y_pos(a_y), .video_on(a_von), .hsync(a_hs), .vsync(a_vs),
    .frame_start(a_fs), .vblank_start(a_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(1), .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(b_pt), .x_pos(b_x),
    .y_pos(b_y), .video_on(b_von), .hsync(b_hs), .vsync(b_vs),
    .frame_start(b_fs), .vblank_start(b_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(3), .SYNC_ACTIVE_LOW(1)
  ) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(c_pt), .x_pos(c_x),
    .y_pos(c_y), .video_on(c_von), .hsync(c_hs), .vsync(c_vs),
    .frame_start(c_fs), .vblank_start(c_vb)
  );

  // Reference bookkeeping: number of enabled edges since reset, and whether the last edge was enabled.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_cnt   <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= enable;
      if (enable) e_cnt <= e_cnt + 1;
    end
  end

  // Expected outputs from the raster rules: pixel n (0-based) is shown after advance n+1.
  function automatic vec_t model(input int e, input bit le, input int hact, input int hfp,
                                 input int hsw, input int hbp, input int vact, input int vfp,
                                 input int vsw, input int vbp, input int div, input bit al);
    vec_t m;
    int ht, vt, adv, p, xi, yi;
    bit hin, vin;
    ht  = hact + hfp + hsw + hbp;
    vt  = vact + vfp + vsw + vbp;
    adv = e / div;
    if (adv == 0) begin
      xi = ht - 1;
      yi = vt - 1;
    end else begin
      p  = (adv - 1) % (ht * vt);
      xi = p % ht;
      yi = p / ht;
    end
    hin   = (xi >= hact + hfp) && (xi < hact + hfp + hsw);
    vin   = (yi >= vact + vfp) && (yi < vact + vfp + vsw);
    m.x   = 10'(xi);
    m.y   = 10'(yi);
    m.pt  = le && (e > 0) && ((e % div) == 0);
    m.von = (xi < hact) && (yi < vact);
    m.hs  = al ? !hin : hin;
    m.vs  = al ? !vin : vin;
    m.fs  = m.pt && (xi == 0) && (yi == 0);
    m.vb  = m.pt && (xi == 0) && (yi == vact);
    return m;
  endfunction

  task automatic check_vec(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b vb=%b expected pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b vb=%b",
             tag, cyc, obs.pt, obs.x, obs.y, obs.von, obs.hs, obs.vs, obs.fs, obs.vb,
             exp.pt, exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.fs, exp.vb);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    check_vec("dut_a", obs_a, model(e_cnt, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b1));
    check_vec("dut_b", obs_b, model(e_cnt, last_en, 8, 2, 3, 2, 6, 1, 2, 2, 1, 1'b0));
    check_vec("dut_c", obs_c, model(e_cnt, last_en, 8, 2, 3, 2, 6, 1, 2, 2, 3, 1'b1));
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    int  hs_low;
    int  last_b, last_c;
    bit  found;

    // Reset held: parked state on every instance.
    repeat (3) step();
    check_val("rst_x", a_x, 799);
    check_val("rst_y", a_y, 524);
    check_val("rst_hsync", a_hs, 1);
    check_val("rst_b_hsync", b_hs, 0);

    // Release with enable high: first default advance on edge 2.
    reset = 1'b0;
    step();
    check_val("edge1_x", a_x, 799);
    check_val("edge1_fs", a_fs, 0);
    step();
    check_val("edge2_x", a_x, 0);
    check_val("edge2_y", a_y, 0);
    check_val("edge2_pt", a_pt, 1);
    check_val("edge2_fs", a_fs, 1);
    check_val("edge2_von", a_von, 1);
    check_val("edge2_hs", a_hs, 1);
    check_val("edge2_vs", a_vs, 1);
    step();
    check_val("edge3_pt", a_pt, 0);
    check_val("edge3_fs", a_fs, 0);

    // One full default line plus the wrap into line 1.
    hs_low = 0;
    for (int i = 0; i < 1700; i++) begin
      step();
      if (a_y == 10'd0 && a_hs == 1'b0) hs_low++;
    end
    check_val("line0_hsync_low_cycles", hs_low, 192);
    check_val("line1_y", a_y, 1);

    // Hold mid-line at x=100.
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      step();
      if (a_pt && a_x == 10'd100) found = 1'b1;
    end
    check_val("wait_x100", found, 1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("hold_x", a_x, 100);
      check_val("hold_pt", a_pt, 0);
    end
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (a_pt) found = 1'b1;
    end
    check_val("resume_tick", found, 1);
    check_val("resume_x", a_x, 101);

    // Random enable pattern.
    for (int i = 0; i < 3000; i++) begin
      step();
      enable = ($urandom_range(0, 9) != 0);
    end

    // Free run: frame_start periods on the small rasters.
    enable = 1'b1;
    last_b = -1;
    last_c = -1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (b_fs) begin
        if (last_b >= 0) check_val("b_frame_period", cyc - last_b, 165);
        last_b = cyc;
      end
      if (c_fs) begin
        if (last_c >= 0) check_val("c_frame_period", cyc - last_c, 495);
        last_c = cyc;
      end
    end
    check_val("b_saw_frames", (last_b >= 0), 1);
    check_val("c_saw_frames", (last_c >= 0), 1);

    // Asynchronous reset mid-line at x=300.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step();
      if (a_pt && a_x == 10'd300) found = 1'b1;
    end
    check_val("wait_x300", found, 1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check_all();
    check_val("arst_x", a_x, 799);
    check_val("arst_y", a_y, 524);
    check_val("arst_von", a_von, 0);
    check_val("arst_hs", a_hs, 1);
    check_val("arst_vs", a_vs, 1);
    check_val("arst_fs", a_fs, 0);
    repeat (2) step();
    reset = 1'b0;
    step();
    check_val("restart_edge1_fs", a_fs, 0);
    step();
    check_val("restart_edge2_fs", a_fs, 1);
    check_val("restart_edge2_x", a_x, 0);
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
